algo_1r2w1p_rdresp_buf: RTL and testbench

//  Read-side stage between read clients and the 1R2W1P memory wrapper.
//  The wrapper has fixed read latency and no backpressure, so this block issues reads only against reserved buffer credits.
//  It captures every rd_vld/rd_dout/rd_serr/rd_derr/rd_padr beat into a credit-protected FIFO.
//  It returns the beats to the consumer over a valid/ready handshake, in issue order.

---
 rtl/algo_1r2w1p_rdresp_buf_pkg.sv | 19 +
 rtl/algo_1r2w1p_rdresp_buf_if.sv | 55 +++++
 rtl/algo_1r2w1p_rdresp_buf_fifo.sv | 58 +++++
 rtl/algo_1r2w1p_rdresp_buf.sv | 122 ++++++++++++
 tb/tb_algo_1r2w1p_rdresp_buf.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/algo_1r2w1p_rdresp_buf_pkg.sv
// Shared types and defaults for the read-response buffer.
// FSM states and packed response entry width.
package algo_rdresp_pkg;

  localparam int DEF_WIDTH   = 64;
  localparam int DEF_BITADDR = 13;
  localparam int DEF_BITPADR = 15;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_BITDPTH = 3;

  localparam int RESP_W = DEF_WIDTH + 2 + DEF_BITPADR;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/algo_1r2w1p_rdresp_buf_if.sv
// Client, memory and consumer signals of the read-response buffer.
// slave = buffer view, master = environment view.
interface algo_1r2w1p_rdresp_buf_if
  import algo_rdresp_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int BITADDR = DEF_BITADDR,
  parameter int BITPADR = DEF_BITPADR
);

  logic               cl_read;
  logic [BITADDR-1:0] cl_rd_adr;
  logic               cl_rdy;

  logic               mem_ready;
  logic               mem_read;
  logic [BITADDR-1:0] mem_rd_adr;
  logic               mem_rd_vld;
  logic [WIDTH-1:0]   mem_rd_dout;
  logic               mem_rd_serr;
  logic               mem_rd_derr;
  logic [BITPADR-1:0] mem_rd_padr;

  logic               out_vld;
  logic               out_rdy;
  logic [WIDTH-1:0]   out_dout;
  logic               out_serr;
  logic               out_derr;
  logic [BITPADR-1:0] out_padr;

  modport slave (
    input  cl_read, cl_rd_adr,
    output cl_rdy,
    input  mem_ready,
    output mem_read, mem_rd_adr,
    input  mem_rd_vld, mem_rd_dout,
    input  mem_rd_serr, mem_rd_derr, mem_rd_padr,
    output out_vld, out_dout,
    output out_serr, out_derr, out_padr,
    input  out_rdy
  );

  modport master (
    output cl_read, cl_rd_adr,
    input  cl_rdy,
    output mem_ready,
    input  mem_read, mem_rd_adr,
    output mem_rd_vld, mem_rd_dout,
    output mem_rd_serr, mem_rd_derr, mem_rd_padr,
    input  out_vld, out_dout,
    input  out_serr, out_derr, out_padr,
    output out_rdy
  );

endinterface

// File: rtl/algo_1r2w1p_rdresp_buf_fifo.sv
// Synchronous show-ahead FIFO; head entry visible on dout.
// Push on full is accepted only together with a pop.
module algo_rdresp_fifo #(
  parameter int W       = 8,
  parameter int DEPTH   = 8,
  parameter int BITDPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [BITDPTH:0] count
);

  localparam logic [BITDPTH:0] C_DEPTH = (BITDPTH+1)'(DEPTH);
  localparam logic [BITDPTH:0] C_ONE   = (BITDPTH+1)'(1);

  logic [W-1:0]       mem_q [DEPTH];
  logic [BITDPTH-1:0] wr_q;
  logic [BITDPTH-1:0] rd_q;
  logic [BITDPTH:0]   cnt_q;
  logic               do_push;
  logic               do_pop;

  assign full    = (cnt_q == C_DEPTH);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + C_ONE;
        2'b01:   cnt_q <= cnt_q - C_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/algo_1r2w1p_rdresp_buf.sv
// Credit-gated read issue to the memory wrapper and
// in-order return of response beats over valid/ready.
module algo_1r2w1p_rdresp_buf
  import algo_rdresp_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int BITADDR = DEF_BITADDR,
  parameter int BITPADR = DEF_BITPADR,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int BITDPTH = DEF_BITDPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  algo_1r2w1p_rdresp_buf_if.slave  bus,
  output logic [BITDPTH:0]         credits,
  output logic                     err_unexp,
  output logic                     err_ovf
);

  localparam int EW = WIDTH + 2 + BITPADR;
  localparam logic [BITDPTH:0] C_DEPTH = (BITDPTH+1)'(DEPTH);
  localparam logic [BITDPTH:0] C_ONE   = (BITDPTH+1)'(1);

  state_e           state_q;
  state_e           state_d;
  logic [BITDPTH:0] rsv_q;
  logic [BITDPTH:0] ost_q;
  logic             unexp_q;
  logic             ovf_q;
  logic             cl_rdy;
  logic             issue;
  logic             pop;
  logic             beat_ok;
  logic             unexp;
  logic             ovf;
  logic             push;
  logic             f_full;
  logic             f_empty;
  logic [BITDPTH:0] f_cnt;
  logic [EW-1:0]    f_din;
  logic [EW-1:0]    f_dout;

  // Next state and issue gating from the memory ready level.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (bus.mem_ready)  state_d = RUN;
      RUN:     if (!bus.mem_ready) state_d = HOLD;
      HOLD:    if (bus.mem_ready)  state_d = RUN;
      default: state_d = INIT;
    endcase
    cl_rdy = (state_q == RUN) && bus.mem_ready
          && (rsv_q < C_DEPTH);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= INIT;
    else      state_q <= state_d;
  end

  assign issue   = bus.cl_read && cl_rdy;
  assign pop     = bus.out_rdy && !f_empty;
  assign beat_ok = bus.mem_rd_vld
                && ((ost_q != '0) || issue);
  assign unexp   = bus.mem_rd_vld && !beat_ok;
  assign ovf     = beat_ok && f_full && !pop;
  assign push    = beat_ok && !ovf;

  assign bus.cl_rdy     = cl_rdy;
  assign bus.mem_read   = issue;
  assign bus.mem_rd_adr = bus.cl_rd_adr;
  assign bus.out_vld    = (f_cnt != '0);
  assign credits        = C_DEPTH - rsv_q;
  assign err_unexp      = unexp_q;
  assign err_ovf        = ovf_q;

  assign f_din = {bus.mem_rd_dout, bus.mem_rd_serr,
                  bus.mem_rd_derr, bus.mem_rd_padr};
  assign {bus.out_dout, bus.out_serr,
          bus.out_derr, bus.out_padr} = f_dout;

  // Credit, outstanding-read and sticky error tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsv_q   <= '0;
      ost_q   <= '0;
      unexp_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case ({issue, pop})
        2'b10:   rsv_q <= rsv_q + C_ONE;
        2'b01:   rsv_q <= rsv_q - C_ONE;
        default: rsv_q <= rsv_q;
      endcase
      unique case ({issue, beat_ok})
        2'b10:   ost_q <= ost_q + C_ONE;
        2'b01:   ost_q <= ost_q - C_ONE;
        default: ost_q <= ost_q;
      endcase
      if (unexp) unexp_q <= 1'b1;
      if (ovf)   ovf_q   <= 1'b1;
    end
  end

  algo_rdresp_fifo #(
    .W       (EW),
    .DEPTH   (DEPTH),
    .BITDPTH (BITDPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (f_din),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

endmodule

// File: tb/tb_algo_1r2w1p_rdresp_buf.sv
// Directed bench for the read-response buffer with a
// fixed-latency memory model and an in-order scoreboard.
module tb_algo_1r2w1p_rdresp_buf;
  import algo_rdresp_pkg::*;

  localparam int D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [DEF_BITDPTH:0] credits;
  logic                 err_unexp;
  logic                 err_ovf;

  algo_1r2w1p_rdresp_buf_if bus ();

  algo_1r2w1p_rdresp_buf dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .credits   (credits),
    .err_unexp (err_unexp),
    .err_ovf   (err_ovf)
  );

  typedef struct packed {
    logic                   v;
    logic [DEF_BITADDR-1:0] a;
    logic                   s;
    logic                   d;
    logic [DEF_BITPADR-1:0] p;
  } req_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0]   dout;
    logic                   s;
    logic                   d;
    logic [DEF_BITPADR-1:0] p;
  } exp_t;

  req_t pipe [D];
  exp_t exp_q [$];

  int total = 0;
  int bad   = 0;
  int n_issue = 0;
  int n_pop   = 0;
  logic last_iss;
  logic inj_s, inj_d, inj_p_en, stray;
  logic [DEF_BITPADR-1:0] inj_p;
  logic [DEF_BITADDR-1:0] adr;

  function automatic logic [DEF_WIDTH-1:0] dat(
    input logic [DEF_BITADDR-1:0] a);
    return {16'hD0DA, 35'd0, a};
  endfunction

  function automatic logic [DEF_BITPADR-1:0] padr_of(
    input logic [DEF_BITADDR-1:0] a);
    return {2'b10, a};
  endfunction

  // One clock: sample issue/pop at negedge, then drive responses.
  task automatic step();
    req_t r;
    exp_t e;
    exp_t h;
    @(negedge clk);
    last_iss = 1'b0;
    r = '0;
    if (bus.mem_read === 1'b1) begin
      last_iss = 1'b1;
      n_issue++;
      r.v = 1'b1;
      r.a = bus.mem_rd_adr;
      r.s = inj_s;
      r.d = inj_d;
      r.p = inj_p_en ? inj_p : padr_of(bus.mem_rd_adr);
      exp_q.push_back({dat(r.a), r.s, r.d, r.p});
    end
    if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
      n_pop++;
      total++;
      h = {bus.out_dout, bus.out_serr,
           bus.out_derr, bus.out_padr};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_extra: got %h want none", h);
      end else begin
        e = exp_q.pop_front();
        if (h !== e) begin
          bad++;
          $display("FAIL pop_data: got %h want %h", h, e);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = D - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = r;
    bus.mem_rd_vld  = pipe[D-1].v;
    bus.mem_rd_dout = dat(pipe[D-1].a);
    bus.mem_rd_serr = pipe[D-1].s;
    bus.mem_rd_derr = pipe[D-1].d;
    bus.mem_rd_padr = pipe[D-1].p;
    if (stray) begin
      bus.mem_rd_vld  = 1'b1;
      bus.mem_rd_dout = '1;
      bus.mem_rd_padr = '0;
      stray = 1'b0;
    end
    #2;
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++;
    if (bus.out_vld !== 1'b0) begin
      bad++;
      $display("FAIL rst_out_vld: got %b want 0", bus.out_vld);
    end
    total++;
    if (credits !== 4'd8) begin
      bad++;
      $display("FAIL rst_credits: got %0d want 8", credits);
    end
    total++;
    if ({err_unexp, err_ovf} !== 2'b00) begin
      bad++;
      $display("FAIL rst_err: got %b%b want 00", err_unexp, err_ovf);
    end
    rst = 1'b1;
    bus.cl_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (bus.cl_rdy !== 1'b0 || last_iss) begin
        bad++;
        $display("FAIL init_rdy: got %b want 0", bus.cl_rdy);
      end
    end
    bus.cl_read = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if (bus.cl_rdy !== 1'b0) begin
      bad++;
      $display("FAIL init_rdy_same: got %b want 0", bus.cl_rdy);
    end
    step();
    total++;
    if (bus.cl_rdy !== 1'b1) begin
      bad++;
      $display("FAIL run_rdy: got %b want 1", bus.cl_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int b_iss;
    int b_pop;
    int k;
    b_iss = n_issue;
    bus.out_rdy = 1'b0;
    adr = 13'h100;
    bus.cl_rd_adr = adr;
    bus.cl_read = 1'b1;
    repeat (12) begin
      step();
      if (last_iss) begin
        adr++;
        bus.cl_rd_adr = adr;
      end
    end
    total++;
    if (n_issue - b_iss != 8) begin
      bad++;
      $display("FAIL b2b_accepted: got %0d want 8", n_issue - b_iss);
    end
    total++;
    if (bus.cl_rdy !== 1'b0 || bus.mem_read !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stall: got %b want 0", bus.cl_rdy);
    end
    total++;
    if (credits !== 4'd0) begin
      bad++;
      $display("FAIL b2b_credits: got %0d want 0", credits);
    end
    total++;
    if (bus.out_vld !== 1'b1 || bus.out_dout !== dat(13'h100)) begin
      bad++;
      $display("FAIL b2b_head: got %h want %h", bus.out_dout, dat(13'h100));
    end
    bus.cl_read = 1'b0;
    bus.out_rdy = 1'b1;
    b_pop = n_pop;
    step();
    total++;
    if (bus.cl_rdy !== 1'b1 || credits !== 4'd1) begin
      bad++;
      $display("FAIL b2b_free: got rdy=%b cr=%0d want 1/1", bus.cl_rdy, credits);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      step();
      k++;
    end
    step();
    total++;
    if (n_pop - b_pop != 8 || bus.out_vld !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: got %0d want 8", n_pop - b_pop);
    end
  endtask

  task automatic test_stream();
    int miss;
    int gaps;
    int k;
    miss = 0;
    gaps = 0;
    bus.out_rdy = 1'b1;
    adr = 13'h200;
    bus.cl_rd_adr = adr;
    bus.cl_read = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (last_iss) begin
        adr++;
        bus.cl_rd_adr = adr;
      end else begin
        miss++;
      end
      if (c >= 3 && bus.out_vld !== 1'b1) gaps++;
    end
    total++;
    if (miss != 0) begin
      bad++;
      $display("FAIL stream_issue: got %0d missed want 0", miss);
    end
    total++;
    if (gaps != 0) begin
      bad++;
      $display("FAIL stream_vld: got %0d gaps want 0", gaps);
    end
    bus.cl_read = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || bus.out_vld === 1'b1) && k < 20) begin
      step();
      k++;
    end
    total++;
    if (exp_q.size() != 0 || credits !== 4'd8) begin
      bad++;
      $display("FAIL stream_drain: got %0d cr=%0d want 0/8", exp_q.size(), credits);
    end
    total++;
    if ({err_unexp, err_ovf} !== 2'b00) begin
      bad++;
      $display("FAIL stream_err: got %b%b want 00", err_unexp, err_ovf);
    end
  endtask

  task automatic test_ecc_flags();
    logic [DEF_BITADDR-1:0] a;
    logic ws, wd;
    logic [DEF_BITPADR-1:0] wp;
    int k;
    for (int t = 0; t < 2; t++) begin
      a  = (t == 0) ? 13'h0AA : 13'h0AB;
      ws = (t == 0);
      wd = (t != 0);
      wp = (t == 0) ? 15'h1234 : padr_of(a);
      bus.out_rdy = 1'b0;
      inj_s = ws;
      inj_d = wd;
      inj_p_en = (t == 0);
      inj_p = 15'h1234;
      bus.cl_rd_adr = a;
      bus.cl_read = 1'b1;
      step();
      bus.cl_read = 1'b0;
      inj_s = 1'b0;
      inj_d = 1'b0;
      inj_p_en = 1'b0;
      total++;
      if (!last_iss) begin
        bad++;
        $display("FAIL ecc_issue: got 0 want 1");
      end
      k = 0;
      while (bus.out_vld !== 1'b1 && k < 10) begin
        step();
        k++;
      end
      total++;
      if ({bus.out_vld, bus.out_serr, bus.out_derr} !== {1'b1, ws, wd}) begin
        bad++;
        $display("FAIL ecc_flags: got %b%b%b want 1%b%b", bus.out_vld, bus.out_serr, bus.out_derr, ws, wd);
      end
      total++;
      if (bus.out_padr !== wp || bus.out_dout !== dat(a)) begin
        bad++;
        $display("FAIL ecc_padr: got %h want %h", bus.out_padr, wp);
      end
      bus.out_rdy = 1'b1;
      step();
      bus.out_rdy = 1'b0;
    end
  endtask

  task automatic test_unexpected();
    bus.out_rdy = 1'b0;
    stray = 1'b1;
    step();
    step();
    total++;
    if (err_unexp !== 1'b1 || err_ovf !== 1'b0) begin
      bad++;
      $display("FAIL unexp_set: got %b%b want 10", err_unexp, err_ovf);
    end
    total++;
    if (bus.out_vld !== 1'b0 || credits !== 4'd8) begin
      bad++;
      $display("FAIL unexp_drop: got %b cr=%0d want 0/8", bus.out_vld, credits);
    end
    repeat (3) step();
    total++;
    if (err_unexp !== 1'b1) begin
      bad++;
      $display("FAIL unexp_sticky: got %b want 1", err_unexp);
    end
  endtask

  task automatic test_hold_reset();
    int b_iss;
    b_iss = n_issue;
    bus.out_rdy = 1'b0;
    adr = 13'h300;
    bus.cl_rd_adr = adr;
    bus.cl_read = 1'b1;
    repeat (3) begin
      step();
      if (last_iss) begin
        adr++;
        bus.cl_rd_adr = adr;
      end
    end
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (bus.cl_rdy !== 1'b0) begin
      bad++;
      $display("FAIL hold_rdy: got %b want 0", bus.cl_rdy);
    end
    repeat (4) step();
    total++;
    if (n_issue - b_iss != 3) begin
      bad++;
      $display("FAIL hold_issue: got %0d want 3", n_issue - b_iss);
    end
    total++;
    if (bus.out_vld !== 1'b1 || credits !== 4'd5) begin
      bad++;
      $display("FAIL hold_capture: got %b cr=%0d want 1/5", bus.out_vld, credits);
    end
    bus.out_rdy = 1'b1;
    repeat (2) step();
    total++;
    if (credits !== 4'd7 || exp_q.size() != 1) begin
      bad++;
      $display("FAIL hold_drain: got cr=%0d want 7", credits);
    end
    bus.out_rdy = 1'b0;
    bus.cl_read = 1'b0;
    rst = 1'b0;
    step();
    exp_q.delete();
    total++;
    if (bus.out_vld !== 1'b0 || credits !== 4'd8) begin
      bad++;
      $display("FAIL mid_rst: got %b cr=%0d want 0/8", bus.out_vld, credits);
    end
    total++;
    if ({err_unexp, bus.cl_rdy} !== 2'b00) begin
      bad++;
      $display("FAIL mid_rst_err: got %b%b want 00", err_unexp, bus.cl_rdy);
    end
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (2) step();
    total++;
    if (bus.cl_rdy !== 1'b1) begin
      bad++;
      $display("FAIL rerun_rdy: got %b want 1", bus.cl_rdy);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.cl_read = 1'b0;
    bus.cl_rd_adr = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rd_vld = 1'b0;
    bus.mem_rd_dout = '0;
    bus.mem_rd_serr = 1'b0;
    bus.mem_rd_derr = 1'b0;
    bus.mem_rd_padr = '0;
    bus.out_rdy = 1'b0;
    inj_s = 1'b0;
    inj_d = 1'b0;
    inj_p_en = 1'b0;
    inj_p = '0;
    stray = 1'b0;
    last_iss = 1'b0;
    adr = '0;
    for (int i = 0; i < D; i++) pipe[i] = '0;
    test_reset();
    test_back_to_back();
    test_stream();
    test_ecc_flags();
    test_unexpected();
    test_hold_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
